serial_transmitter: RTL and testbench

SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

---
 rtl/serial_transmitter_pkg.sv | 17 +
 rtl/tx_bit_timer.sv | 23 ++
 rtl/serial_transmitter.sv | 91 +++++++++
 tb/tb_serial_transmitter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/serial_transmitter_pkg.sv
// serial_transmitter_pkg: shared FSM encoding and line-level constants for serial_transmitter
package serial_transmitter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/tx_bit_timer.sv
// tx_bit_timer: counts 0..BIT_CYCLES-1 per bit, tick on the last cycle of each bit
// ports: clk, rst (async, active-high), restart (hold count at 0), tick (last cycle of a bit)
module tx_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = cnt == 8'(BIT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= (restart || tick) ? 8'd0 : cnt + 8'd1;
    end

endmodule

// File: rtl/serial_transmitter.sv
// serial_transmitter: frames an 8-bit word as start, LSB-first data, optional even parity, stop
// ports: clk, rst (async, active-high), wake (one-cycle send request), data_in (word to send),
//        serial_out (registered line, idle high), busy (frame in progress), done (completion pulse)
module serial_transmitter
    import serial_transmitter_pkg::*;
#(
    parameter int BIT_CYCLES = 1,
    parameter bit PARITY_EN  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wake,
    input  logic [7:0] data_in,
    output logic       serial_out,
    output logic       busy,
    output logic       done
);

    state_t     state, state_nx;
    logic [7:0] shift, shift_nx;
    logic [3:0] idx, idx_nx;
    logic       par, par_nx;
    logic       so_nx, done_nx, tick;

    // Timer is held at zero while idle so the first start-bit cycle is count 0.
    tx_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(state == IDLE),
        .tick   (tick)
    );

    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= '0;
            idx        <= '0;
            par        <= 1'b0;
            serial_out <= IDLE_LEVEL;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            shift      <= shift_nx;
            idx        <= idx_nx;
            par        <= par_nx;
            serial_out <= so_nx;
            done       <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        shift_nx = shift;
        idx_nx   = idx;
        par_nx   = par;
        done_nx  = 1'b0;
        case (state)
            IDLE: if (wake) begin
                state_nx = START;
                shift_nx = data_in;
                par_nx   = ^data_in;
            end
            START: if (tick) begin
                state_nx = DATA;
                idx_nx   = '0;
            end
            DATA: if (tick) begin
                if (idx == 4'(DATA_BITS - 1))
                    state_nx = PARITY_EN ? PARITY : STOP;
                else begin
                    idx_nx   = idx + 4'd1;
                    shift_nx = shift >> 1;
                end
            end
            PARITY: if (tick) state_nx = STOP;
            STOP: if (tick) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        // Line level is registered from the next state so it lines up with the state it belongs to.
        so_nx = state_nx == START  ? START_LEVEL :
                state_nx == DATA   ? shift_nx[0] :
                state_nx == PARITY ? par_nx      :
                state_nx == STOP   ? STOP_LEVEL  : IDLE_LEVEL;
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// tb_serial_transmitter: directed and random frames on four parameterisations against a slot-level model
module tb_serial_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] wake = '0;
    logic [7:0] data [4];
    logic [3:0] so, busy, done;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    serial_transmitter #(.BIT_CYCLES(1), .PARITY_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .wake(wake[0]), .data_in(data[0]), .serial_out(so[0]), .busy(busy[0]), .done(done[0]));
    serial_transmitter #(.BIT_CYCLES(1), .PARITY_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .wake(wake[1]), .data_in(data[1]), .serial_out(so[1]), .busy(busy[1]), .done(done[1]));
    serial_transmitter #(.BIT_CYCLES(4), .PARITY_EN(1'b0)) dut2 (.clk(clk), .rst(rst), .wake(wake[2]), .data_in(data[2]), .serial_out(so[2]), .busy(busy[2]), .done(done[2]));
    serial_transmitter #(.BIT_CYCLES(3), .PARITY_EN(1'b1)) dut3 (.clk(clk), .rst(rst), .wake(wake[3]), .data_in(data[3]), .serial_out(so[3]), .busy(busy[3]), .done(done[3]));

    function automatic int bc_of(input int k);
        return k == 2 ? 4 : k == 3 ? 3 : 1;
    endfunction

    function automatic int pe_of(input int k);
        return (k == 1 || k == 3) ? 1 : 0;
    endfunction

    // Line level of frame slot i: start, d[0..7], optional even parity, stop.
    function automatic logic exp_bit(input logic [7:0] d, input int pe, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (pe == 1 && i == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle. inj>0 fires an extra wake in that busy cycle.
    task automatic send_check(input int k, input logic [7:0] d, input int inj);
        int bc = bc_of(k);
        int pe = pe_of(k);
        int len = (10 + pe) * bc;
        wake[k] = 1'b1;
        data[k] = d;
        @(posedge clk);
        #1 wake[k] = 1'b0;
        data[k] = 8'($urandom);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            chk($sformatf("k%0d d%02h c%0d so", k, d, c), 8'(so[k]), 8'(exp_bit(d, pe, (c - 1) / bc)));
            chk($sformatf("k%0d d%02h c%0d busy", k, d, c), 8'(busy[k]), 8'd1);
            chk($sformatf("k%0d d%02h c%0d done", k, d, c), 8'(done[k]), 8'd0);
            if (c == inj) begin
                wake[k] = 1'b1;
                data[k] = ~d;
                @(posedge clk);
                #1 wake[k] = 1'b0;
            end
        end
        @(negedge clk);
        chk($sformatf("k%0d d%02h end so", k, d), 8'(so[k]), 8'd1);
        chk($sformatf("k%0d d%02h end busy", k, d), 8'(busy[k]), 8'd0);
        chk($sformatf("k%0d d%02h end done", k, d), 8'(done[k]), 8'd1);
    endtask

    task automatic idle_check(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("k%0d idle so", k), 8'(so[k]), 8'd1);
            chk($sformatf("k%0d idle busy", k), 8'(busy[k]), 8'd0);
            chk($sformatf("k%0d idle done", k), 8'(done[k]), 8'd0);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) data[k] = '0;
        #12;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst k%0d so", k), 8'(so[k]), 8'd1);
            chk($sformatf("rst k%0d busy", k), 8'(busy[k]), 8'd0);
            chk($sformatf("rst k%0d done", k), 8'(done[k]), 8'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_check(0, 2);
        send_check(0, 8'hA5, 0);
        idle_check(0, 1);
        send_check(1, 8'h07, 0);
        idle_check(1, 1);
        send_check(1, 8'hA5, 0);
        idle_check(1, 1);
        send_check(2, 8'h01, 0);
        idle_check(2, 1);
        send_check(0, 8'h00, 5);
        send_check(0, 8'h3C, 0);
        idle_check(0, 1);
        wake[0] = 1'b1;
        data[0] = 8'h5A;
        @(posedge clk);
        #1 wake[0] = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst so", 8'(so[0]), 8'd1);
        chk("midrst busy", 8'(busy[0]), 8'd0);
        chk("midrst done", 8'(done[0]), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_check(0, 3);
        send_check(0, 8'hC3, 0);
        send_check(3, 8'h96, 7);
        for (int n = 0; n < 40; n++) begin
            int k = int'($urandom_range(0, 3));
            int len = (10 + pe_of(k)) * bc_of(k);
            send_check(k, 8'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, len)) : 0);
            idle_check(k, int'($urandom_range(0, 2)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
